// File: rtl/dram_arbiter_if.sv
// ============================================================================
// Module      : dram_arbiter_if
// Description : Bus bundle between the CPU path, the VGA line fetcher, the
//               SDRAM controller and the dram_arbiter. The master modport is
//               the arbiter's view; slave is the view of the surrounding
//               requesters and controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_arbiter_if;
    // CPU single-word path
    logic        cpu_req;
    logic [24:0] cpu_addr;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    // VGA burst path
    logic        vga_req;
    logic [24:0] vga_addr;
    logic        vga_ack;
    // SDRAM controller command port
    logic        dram_start;
    logic [24:0] dram_addr;
    logic        dram_write_en;
    logic        dram_burst_en;
    logic [15:0] dram_data_in;
    logic        dram_data_ready;
    logic [15:0] dram_read_data;

    modport master (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_ack,
        output dram_start, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
        input  dram_data_ready, dram_read_data
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_ack,
        input  dram_start, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
        output dram_data_ready, dram_read_data
    );
endinterface

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module      : dram_arbiter
// Description : Shares one SDRAM controller port between the CPU single-word
//               path and the VGA 32-word burst fetcher. Fixed priority to VGA
//               with a consecutive-grant cap that guarantees CPU service.
//               Each access runs IDLE -> ISSUE -> WAIT -> DONE.
//               Optional watchdog: define DRAM_ARB_TIMEOUT_EN to abort a WAIT
//               after TIMEOUT_CYCLES cycles and raise a sticky timeout_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_arbiter #(
    parameter int VGA_MAX_CONSEC = 4,   // 1..15
    parameter int TIMEOUT_CYCLES = 63   // 1..255
) (
    input  wire logic     clk,
    input  wire logic     rst,          // synchronous, active-low
    dram_arbiter_if.master bus,
    output logic          busy,
    output logic          timeout_err
);

    localparam logic [3:0] C_VGA_MAX = 4'(VGA_MAX_CONSEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q,  owner_d;     // 1 = VGA owns the access, 0 = CPU
    logic        first_q,  first_d;     // marks the first WAIT cycle
    logic [24:0] addr_q,   addr_d;
    logic        we_q,     we_d;
    logic        burst_q,  burst_d;
    logic [15:0] wdata_q,  wdata_d;
    logic [15:0] rdata_q,  rdata_d;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  wcnt_q,   wcnt_d;
    logic        terr_q,   terr_d;
`endif

    // Next-state, grant decision and command latching
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        first_d  = first_q;
        addr_d   = addr_q;
        we_d     = we_q;
        burst_d  = burst_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef DRAM_ARB_TIMEOUT_EN
        wcnt_d   = wcnt_q;
        terr_d   = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.vga_req && (!bus.cpu_req || streak_q < C_VGA_MAX)) begin
                    state_d = S_ISSUE;
                    owner_d = 1'b1;
                    addr_d  = bus.vga_addr;
                    burst_d = 1'b1;
                    we_d    = 1'b0;
                    // Only count VGA wins that actually held off the CPU
                    if (!bus.cpu_req)
                        streak_d = 4'd0;
                    else if (streak_q != 4'hF)
                        streak_d = streak_q + 4'd1;
                end else if (bus.cpu_req) begin
                    state_d  = S_ISSUE;
                    owner_d  = 1'b0;
                    addr_d   = bus.cpu_addr;
                    burst_d  = 1'b0;
                    we_d     = bus.cpu_we;
                    wdata_d  = bus.cpu_wdata;
                    streak_d = 4'd0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                first_d = 1'b1;
`ifdef DRAM_ARB_TIMEOUT_EN
                wcnt_d  = 8'd0;
`endif
            end
            S_WAIT: begin
                first_d = 1'b0;
                // Ready is stale in the first WAIT cycle: the controller is
                // still reacting to the start strobe.
                if (!first_q && bus.dram_data_ready) begin
                    state_d = S_DONE;
                    if (!owner_q && !we_q)
                        rdata_d = bus.dram_read_data;
                end
`ifdef DRAM_ARB_TIMEOUT_EN
                else begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_q + 8'd1 == C_TIMEOUT) begin
                        state_d = S_DONE;
                        terr_d  = 1'b1;
                        if (!owner_q && !we_q)
                            rdata_d = 16'hFFFF;
                    end
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= 25'd0;
            we_q     <= 1'b0;
            burst_q  <= 1'b0;
            wdata_q  <= 16'd0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            burst_q  <= burst_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_q <= 8'd0;
            terr_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_err    = 1'b0;
`endif

    // Strobes and acks decode straight from state so reset forces them low
    assign bus.dram_start    = (state_q == S_ISSUE);
    assign bus.cpu_ack       = (state_q == S_DONE) && !owner_q;
    assign bus.vga_ack       = (state_q == S_DONE) &&  owner_q;
    assign busy              = (state_q != S_IDLE);
    assign bus.dram_addr     = addr_q;
    assign bus.dram_write_en = we_q;
    assign bus.dram_burst_en = burst_q;
    assign bus.dram_data_in  = wdata_q;
    assign bus.cpu_rdata     = rdata_q;

endmodule

`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single SDRAM controller port between the CPU memory path (single-word read/write) and the VGA line fetcher (32-word burst read). Sits between those requesters and the DRAM controller, and sequences each access as start strobe, wait for ready, then acknowledge. Arbitration is fixed-priority to VGA with a starvation cap that guarantees CPU service. A watchdog that can be compiled in or out bounds every access.

## Interface
Parameters:
- VGA_MAX_CONSEC, 4: maximum back-to-back VGA grants while CPU is requesting (1..15)
- TIMEOUT_CYCLES, 63: WAIT cycles before watchdog abort (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_addr  in  25  CPU word address
- cpu_we  in  1  1 = write, 0 = read
- cpu_wdata  in  16  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid from cpu_ack onward
- vga_req  in  1  VGA burst request, level, held until vga_ack
- vga_addr  in  25  burst base address, bits [4:0] are zero
- vga_ack  out  1  one-cycle pulse; burst buffer in controller is valid
- dram_start  out  1  one-cycle command strobe to controller
- dram_addr  out  25  command address
- dram_write_en  out  1  write command
- dram_burst_en  out  1  burst-read command
- dram_data_in  out  16  write data
- dram_data_ready  in  1  controller done/ready level
- dram_read_data  in  16  controller single-word read data
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if vga_req && (!cpu_req || streak < VGA_MAX_CONSEC), grant VGA. Otherwise, if cpu_req, grant CPU. Otherwise stay in IDLE.
- On a grant, latch the owner, dram_addr, dram_write_en, dram_burst_en and dram_data_in, then go to ISSUE.
- VGA grant: dram_addr = vga_addr, burst_en = 1, write_en = 0. CPU grant: dram_addr = cpu_addr, burst_en = 0, write_en = cpu_we, data_in = cpu_wdata.
- streak is a 4-bit counter. It increments (saturating) on a VGA grant made while cpu_req is high. It clears on a CPU grant, and on a VGA grant made while cpu_req is low.
- ISSUE: dram_start = 1 for exactly this cycle, then go to WAIT.
- WAIT: dram_data_ready is ignored in the first WAIT cycle, because the controller drops ready in response to the start strobe. From the second WAIT cycle, ready = 1 moves the block to DONE. For a CPU read, cpu_rdata <= dram_read_data on that transition.
- DONE: the owner's ack = 1 for this cycle only, then go to IDLE. Command outputs hold their values until the next grant.
- A requester deasserts req in the cycle after ack. Because IDLE follows DONE, a req still high in that cycle is treated as a new request.
- Outputs not listed in a state hold their value.
- Reset (any state, including mid-access): state = IDLE, streak = 0, wait counter = 0. All outputs read 0: cpu_ack, vga_ack, cpu_rdata, dram_start, dram_addr, dram_write_en, dram_burst_en, dram_data_in, busy, timeout_err. No ack is issued for an aborted access.

## Timing
- req sampled high in IDLE at cycle N: ISSUE (dram_start) at N+1, first WAIT at N+2.
- If ready is high at N+3, DONE/ack is at N+4. This is the minimum req→ack latency of 4 cycles.
- Back-to-back grants: the next ISSUE is at the earliest 2 cycles after DONE (DONE→IDLE→ISSUE).
- With both requesters continuously requesting, CPU is granted at least once every VGA_MAX_CONSEC+1 grants.

## Configuration
- DRAM_ARB_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on ISSUE and increments each WAIT cycle.
  - Counter == TIMEOUT_CYCLES with no ready: go to DONE, pulse the owner's ack, and set timeout_err = 1 (sticky until reset).
  - A CPU read that times out returns cpu_rdata = 16'hFFFF.
- DRAM_ARB_TIMEOUT_EN undefined:
  - WAIT holds indefinitely until ready.
  - timeout_err is tied to 0 and no counter is built.

## Test plan
- CPU read only, cpu_addr = 0x00123, controller returns 0xBEEF with ready 3 cycles after start -> one dram_start with addr 0x00123, burst_en = 0, write_en = 0; cpu_ack pulses once; cpu_rdata = 0xBEEF; vga_ack never asserts.
- CPU write 0x5A5A to 0x0F7FF -> dram_start with write_en = 1, dram_data_in = 0x5A5A, burst_en = 0; cpu_ack pulses once.
- vga_req and cpu_req both held continuously, VGA_MAX_CONSEC = 4 -> grant order V,V,V,V,C,V,V,V,V,C; every VGA command has burst_en = 1 and addr = vga_addr.
- Simultaneous requests from IDLE after reset -> VGA is granted first; minimum latency is 4 cycles req→ack when ready asserts in the second WAIT cycle.
- Reset asserted in WAIT during a CPU read -> next cycle all outputs are 0 and state is IDLE; no cpu_ack; after release, a held req is re-served normally.
- With DRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 10, ready never asserts on a CPU read -> cpu_ack exactly 10 WAIT cycles after entering WAIT, cpu_rdata = 0xFFFF, timeout_err = 1 and still 1 after the next successful access.
